// File: rtl/ram_arbiter_pkg.sv
// Shared types and default geometry for the two-master RAM arbiter.
package ram_arbiter_pkg;

    // Default RAM port geometry
    localparam int unsigned RA_AW      = 13;
    localparam int unsigned RA_DW      = 8;
    localparam int unsigned RA_LW      = 4;

    // Cycles avalid may sit unacknowledged before the burst is abandoned
    localparam int unsigned RA_TIMEOUT = 255;

    // Burst sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StGap,
        StFinish
    } arb_state_e;

    // Byte address of a beat inside a burst; wraps at the top of the RAM.
    function automatic logic [RA_AW-1:0] beat_addr(input logic [RA_AW-1:0] base,
                                                   input logic [RA_LW-1:0] beat);
        return base + RA_AW'(beat);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker; purely combinational so wider arbiters can reuse it.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        valid = |req;
        grant = 1'b0;
        case (req)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last;
            default: grant = 1'b0;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter and burst sequencer for the byte-wide RAM handshake port.
// Each granted burst is issued as single-byte transactions separated by one idle
// cycle; an unacknowledged transaction aborts the burst after TIMEOUT cycles.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int unsigned AW      = RA_AW,
    parameter int unsigned DW      = RA_DW,
    parameter int unsigned LW      = RA_LW,
    parameter int unsigned TIMEOUT = RA_TIMEOUT
) (
    input  logic          c_clk,
    input  logic          areset,

    input  logic          m0_req,
    input  logic          m0_rnw,
    input  logic [AW-1:0] m0_addr,
    input  logic [LW-1:0] m0_len,
    input  logic [DW-1:0] m0_wdata,
    output logic [LW-1:0] m0_beat,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_rvalid,
    output logic          m0_done,
    output logic          m0_err,

    input  logic          m1_req,
    input  logic          m1_rnw,
    input  logic [AW-1:0] m1_addr,
    input  logic [LW-1:0] m1_len,
    input  logic [DW-1:0] m1_wdata,
    output logic [LW-1:0] m1_beat,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_rvalid,
    output logic          m1_done,
    output logic          m1_err,

    output logic [AW-1:0] raddr,
    output logic          rnw,
    output logic [DW-1:0] rwdata,
    output logic          avalid,
    input  logic [DW-1:0] rrdata,
    input  logic          rack
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] ToLast = TW'(TIMEOUT - 1);

    arb_state_e    state_q;
    logic          gnt_q;
    logic          last_grant_q;
    logic          rnw_q;
    logic [AW-1:0] addr_q;
    logic [LW-1:0] len_q;
    logic [LW-1:0] beat_q;
    logic [TW-1:0] to_cnt_q;

    // Per-master registered outputs, indexed by master number
    logic [LW-1:0] m_beat_q   [2];
    logic [DW-1:0] m_rdata_q  [2];
    logic          m_rvalid_q [2];
    logic          m_done_q   [2];
    logic          m_err_q    [2];

    logic [1:0]    req;
    logic          pick_grant;
    logic          pick_valid;

    logic          sel;
    logic          sel_rnw;
    logic [AW-1:0] sel_addr;
    logic [LW-1:0] sel_len;
    logic [DW-1:0] sel_wdata;
    logic [LW-1:0] beat_nxt;

    assign req = {m1_req, m0_req};

    rr_pick2 u_pick (
        .req   (req),
        .last  (last_grant_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // Steer the master being granted (IDLE) or the one holding the grant (otherwise).
    always_comb begin
        sel       = (state_q == StIdle) ? pick_grant : gnt_q;
        sel_rnw   = sel ? m1_rnw   : m0_rnw;
        sel_addr  = sel ? m1_addr  : m0_addr;
        sel_len   = sel ? m1_len   : m0_len;
        sel_wdata = sel ? m1_wdata : m0_wdata;
        beat_nxt  = beat_q + 1'b1;
    end

    // Burst sequencer: arbitration, beat issue, gap, completion and timeout abort.
    always_ff @(posedge c_clk) begin
        if (areset) begin
            state_q      <= StIdle;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            rnw_q        <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            to_cnt_q     <= '0;
            avalid       <= 1'b0;
            raddr        <= '0;
            rnw          <= 1'b0;
            rwdata       <= '0;
            for (int i = 0; i < 2; i++) begin
                m_beat_q[i]   <= '0;
                m_rdata_q[i]  <= '0;
                m_rvalid_q[i] <= 1'b0;
                m_done_q[i]   <= 1'b0;
                m_err_q[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                m_rvalid_q[i] <= 1'b0;
                m_done_q[i]   <= 1'b0;
                m_err_q[i]    <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        gnt_q    <= pick_grant;
                        rnw_q    <= sel_rnw;
                        addr_q   <= sel_addr;
                        len_q    <= sel_len;
                        beat_q   <= '0;
                        to_cnt_q <= '0;
                        avalid   <= 1'b1;
                        raddr    <= sel_addr;
                        rnw      <= sel_rnw;
                        // Master shows beat 0 while ungranted, so this is beat 0's byte
                        rwdata   <= sel_wdata;
                        state_q  <= StIssue;
                    end
                end

                StIssue: begin
                    if (rack) begin
                        avalid   <= 1'b0;
                        to_cnt_q <= '0;
                        if (rnw_q) begin
                            m_rdata_q[gnt_q]  <= rrdata;
                            m_rvalid_q[gnt_q] <= 1'b1;
                        end else if (beat_q != len_q) begin
                            // Writes advance the visible beat during GAP so the master
                            // presents the next byte in time for the next ISSUE edge.
                            m_beat_q[gnt_q] <= beat_nxt;
                        end
                        state_q <= StGap;
                    end else if (to_cnt_q == ToLast) begin
                        avalid          <= 1'b0;
                        to_cnt_q        <= '0;
                        m_err_q[gnt_q]  <= 1'b1;
                        m_beat_q[gnt_q] <= '0;
                        last_grant_q    <= gnt_q;
                        state_q         <= StIdle;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end

                StGap: begin
                    if (beat_q == len_q) begin
                        m_done_q[gnt_q] <= 1'b1;
                        state_q         <= StFinish;
                    end else begin
                        beat_q          <= beat_nxt;
                        m_beat_q[gnt_q] <= beat_nxt;
                        avalid          <= 1'b1;
                        raddr           <= addr_q + AW'(beat_nxt);
                        rwdata          <= sel_wdata;
                        state_q         <= StIssue;
                    end
                end

                StFinish: begin
                    m_beat_q[gnt_q] <= '0;
                    last_grant_q    <= gnt_q;
                    state_q         <= StIdle;
                end

                default: state_q <= StIdle;
            endcase
        end
    end

    assign m0_beat   = m_beat_q[0];
    assign m0_rdata  = m_rdata_q[0];
    assign m0_rvalid = m_rvalid_q[0];
    assign m0_done   = m_done_q[0];
    assign m0_err    = m_err_q[0];

    assign m1_beat   = m_beat_q[1];
    assign m1_rdata  = m_rdata_q[1];
    assign m1_rvalid = m_rvalid_q[1];
    assign m1_done   = m_done_q[1];
    assign m1_err    = m_err_q[1];

endmodule
